// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - rectangle fill/outline/clear pixel-stream generator for vga_adapter
module rect_plotter #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [1:0]              Mode,
  input  logic [X_WIDTH-1:0]      X0,
  input  logic [Y_WIDTH-1:0]      Y0,
  input  logic [X_WIDTH-1:0]      W,
  input  logic [Y_WIDTH-1:0]      H,
  input  logic [COLOUR_WIDTH-1:0] ColourIn,
  input  logic                    Hold,
  output logic [X_WIDTH-1:0]      X,
  output logic [Y_WIDTH-1:0]      Y,
  output logic [COLOUR_WIDTH-1:0] Colour,
  output logic                    Plot,
  output logic                    Busy,
  output logic                    Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Screen limits widened by one bit so X0+dx / Y0+dy overflow stays off-screen.
  localparam logic [X_WIDTH:0]   SCR_W_EXT = (X_WIDTH+1)'(SCREEN_W);
  localparam logic [Y_WIDTH:0]   SCR_H_EXT = (Y_WIDTH+1)'(SCREEN_H);
  localparam logic [X_WIDTH-1:0] SCR_W_OP  = X_WIDTH'(SCREEN_W);
  localparam logic [Y_WIDTH-1:0] SCR_H_OP  = Y_WIDTH'(SCREEN_H);
  localparam logic [X_WIDTH-1:0] X_ONE     = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_ONE     = Y_WIDTH'(1);

  state_e                  state_q;
  logic [X_WIDTH-1:0]      x0_q, w_q, dx_q;
  logic [Y_WIDTH-1:0]      y0_q, h_q, dy_q;
  logic [COLOUR_WIDTH-1:0] col_q;
  logic                    outline_q;
  logic [X_WIDTH-1:0]      x_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic [COLOUR_WIDTH-1:0] colour_q;
  logic                    plot_q, busy_q, done_q;

  // Operands as they would be latched by a Start this cycle (clear overrides geometry).
  logic                    clear_s;
  logic [X_WIDTH-1:0]      st_x0_d, st_w_d;
  logic [Y_WIDTH-1:0]      st_y0_d, st_h_d;
  logic                    st_empty;

  // Raster successor of the pixel currently on the outputs.
  logic [X_WIDTH-1:0]      dx_d;
  logic [Y_WIDTH-1:0]      dy_d;
  logic                    last_px;

  // A pixel is drawn when it lies on screen and, for outline, on the rectangle border.
  function automatic logic pixel_visible(
    input logic [X_WIDTH-1:0] x0, dx, w,
    input logic [Y_WIDTH-1:0] y0, dy, h,
    input logic               outline
  );
    logic [X_WIDTH:0] xs;
    logic [Y_WIDTH:0] ys;
    logic             on_screen, on_edge;
    xs        = {1'b0, x0} + {1'b0, dx};
    ys        = {1'b0, y0} + {1'b0, dy};
    on_screen = (xs < SCR_W_EXT) && (ys < SCR_H_EXT);
    on_edge   = (dx == '0) || (dx == w - X_ONE) || (dy == '0) || (dy == h - Y_ONE);
    return on_screen && (!outline || on_edge);
  endfunction

  // Effective operands for an operation launched this cycle.
  always_comb begin
    clear_s  = (Mode == 2'b10);
    st_x0_d  = clear_s ? '0       : X0;
    st_y0_d  = clear_s ? '0       : Y0;
    st_w_d   = clear_s ? SCR_W_OP : W;
    st_h_d   = clear_s ? SCR_H_OP : H;
    st_empty = (st_w_d == '0) || (st_h_d == '0);
  end

  // Raster-order step: wrap dx at the right edge and move down one row.
  always_comb begin
    dx_d    = dx_q + X_ONE;
    dy_d    = dy_q;
    last_px = (dx_q == w_q - X_ONE) && (dy_q == h_q - Y_ONE);
    if (dx_q == w_q - X_ONE) begin
      dx_d = '0;
      dy_d = dy_q + Y_ONE;
    end
  end

  // Control FSM with registered pixel outputs; reset aborts silently.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      col_q     <= '0;
      outline_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (Start) begin
            x0_q      <= st_x0_d;
            y0_q      <= st_y0_d;
            w_q       <= st_w_d;
            h_q       <= st_h_d;
            col_q     <= ColourIn;
            outline_q <= (Mode == 2'b01);
            dx_q      <= '0;
            dy_q      <= '0;
            if (st_empty) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_DRAW;
              busy_q   <= 1'b1;
              x_q      <= st_x0_d;
              y_q      <= st_y0_d;
              colour_q <= ColourIn;
              plot_q   <= pixel_visible(st_x0_d, '0, st_w_d, st_y0_d, '0, st_h_d,
                                        (Mode == 2'b01));
            end
          end
        end
        S_DRAW: begin
          if (Hold) begin
            plot_q <= 1'b0;
          end else if (last_px) begin
            state_q <= S_FIN;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            x_q      <= x0_q + dx_d;
            y_q      <= y0_q + dy_d;
            colour_q <= col_q;
            plot_q   <= pixel_visible(x0_q, dx_d, w_q, y0_q, dy_d, h_q, outline_q);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign X      = x_q;
  assign Y      = y_q;
  assign Colour = colour_q;
  assign Plot   = plot_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// tb/tb_rect_plotter.sv - self-checking bench for rect_plotter against a pixel-list model
module tb_rect_plotter;

  logic       Clock = 1'b0;
  logic       Reset, Start, Hold;
  logic [1:0] Mode;
  logic [7:0] X0, W, X;
  logic [6:0] Y0, H, Y;
  logic [2:0] ColourIn, Colour;
  logic       Plot, Busy, Done;

  rect_plotter #(
    .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(3), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
    .X0(X0), .Y0(Y0), .W(W), .H(H), .ColourIn(ColourIn), .Hold(Hold),
    .X(X), .Y(Y), .Colour(Colour), .Plot(Plot), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit busy;
    bit plot;
    bit done;
    int x;
    int y;
    int col;
  } ent_t;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected per-cycle outputs from the cycle after Start: pixel list in raster order,
  // each hold cycle repeats the current pixel unplotted, then one Done cycle.
  task automatic build_trace(input int mode, input int x0, input int y0, input int w,
                             input int h, input int col, input int hs, input int hn);
    int ex0, ey0, ew, eh, i, t, ax, ay;
    bit outl;
    int px[$];
    int py[$];
    bit pv[$];
    ent_t e;
    exp_q.delete();
    if (mode == 2) begin
      ex0 = 0; ey0 = 0; ew = 160; eh = 120;
    end else begin
      ex0 = x0; ey0 = y0; ew = w; eh = h;
    end
    outl = (mode == 1);
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        ax = ex0 + c;
        ay = ey0 + r;
        px.push_back(ax % 256);
        py.push_back(ay % 128);
        pv.push_back((ax < 160) && (ay < 120) &&
                     (!outl || c == 0 || c == ew - 1 || r == 0 || r == eh - 1));
      end
    end
    e.col = col;
    if (px.size() == 0) begin
      e.busy = 0; e.plot = 0; e.done = 1; e.x = 0; e.y = 0;
      exp_q.push_back(e);
      return;
    end
    e.busy = 1; e.done = 0; e.plot = pv[0]; e.x = px[0]; e.y = py[0];
    exp_q.push_back(e);
    i = 0;
    t = 0;
    forever begin
      if (t >= hs && t < hs + hn) begin
        e.plot = 0;
        exp_q.push_back(e);
      end else if (i == px.size() - 1) begin
        e.busy = 0; e.plot = 0; e.done = 1;
        exp_q.push_back(e);
        break;
      end else begin
        i++;
        e.plot = pv[i]; e.x = px[i]; e.y = py[i];
        exp_q.push_back(e);
      end
      t++;
    end
  endtask

  // Launch one operation from IDLE and compare every cycle against the model.
  task automatic run_op(input int mode, input int x0, input int y0, input int w, input int h,
                        input int col, input int hs, input int hn, input bit noise,
                        output int nplot, output int nbusy);
    build_trace(mode, x0, y0, w, h, col, hs, hn);
    nplot = 0;
    nbusy = 0;
    Mode = 2'(mode); X0 = 8'(x0); Y0 = 7'(y0); W = 8'(w); H = 7'(h);
    ColourIn = 3'(col); Start = 1'b1; Hold = 1'b0;
    @(posedge Clock); #1;
    for (int t = 0; t < exp_q.size(); t++) begin
      Hold  = (t >= hs && t < hs + hn);
      Start = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        Mode = 2'($urandom); X0 = 8'($urandom); Y0 = 7'($urandom);
        W = 8'($urandom); H = 7'($urandom); ColourIn = 3'($urandom);
      end
      @(negedge Clock);
      checks++;
      if (Plot !== exp_q[t].plot) begin
        errors++;
        $display("FAIL plot m=%0d t=%0d got=%b exp=%b", mode, t, Plot, exp_q[t].plot);
      end
      checks++;
      if (Busy !== exp_q[t].busy) begin
        errors++;
        $display("FAIL busy m=%0d t=%0d got=%b exp=%b", mode, t, Busy, exp_q[t].busy);
      end
      checks++;
      if (Done !== exp_q[t].done) begin
        errors++;
        $display("FAIL done m=%0d t=%0d got=%b exp=%b", mode, t, Done, exp_q[t].done);
      end
      if (exp_q[t].busy) begin
        checks++;
        if (X !== 8'(exp_q[t].x)) begin
          errors++;
          $display("FAIL x m=%0d t=%0d got=%0d exp=%0d", mode, t, X, exp_q[t].x);
        end
        checks++;
        if (Y !== 7'(exp_q[t].y)) begin
          errors++;
          $display("FAIL y m=%0d t=%0d got=%0d exp=%0d", mode, t, Y, exp_q[t].y);
        end
        checks++;
        if (Colour !== 3'(exp_q[t].col)) begin
          errors++;
          $display("FAIL colour m=%0d t=%0d got=%0d exp=%0d", mode, t, Colour, exp_q[t].col);
        end
      end
      nplot += (Plot === 1'b1) ? 1 : 0;
      nbusy += (Busy === 1'b1) ? 1 : 0;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    Hold  = 1'b0;
    @(negedge Clock);
    checks++;
    if ({Plot, Busy, Done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after m=%0d got pbd=%b exp=000", mode, {Plot, Busy, Done});
    end
    @(posedge Clock); #1;
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({X, Y, Colour, Plot, Busy, Done} !== 21'd0) begin
      errors++;
      $display("FAIL %s got x=%0d y=%0d c=%0d pbd=%b exp all 0", name, X, Y, Colour,
               {Plot, Busy, Done});
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    @(negedge Clock);
    check_all_zero("reset_state");
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check_all_zero("idle_after_reset");
    @(posedge Clock); #1;
  endtask

  task automatic test_fill;
    int np, nb;
    run_op(0, 10, 20, 3, 2, 5, 0, 0, 1'b0, np, nb);
    check_count("fill_plots", np, 6);
    check_count("fill_busy", nb, 6);
    run_op(3, 40, 30, 2, 3, 7, 0, 0, 1'b0, np, nb);
    check_count("mode3_plots", np, 6);
  endtask

  task automatic test_outline;
    int np, nb;
    run_op(1, 0, 0, 4, 3, 2, 0, 0, 1'b0, np, nb);
    check_count("outline_plots", np, 10);
    check_count("outline_busy", nb, 12);
  endtask

  task automatic test_clip;
    int np, nb;
    run_op(0, 158, 119, 4, 2, 3, 0, 0, 1'b0, np, nb);
    check_count("clip_plots", np, 2);
    check_count("clip_busy", nb, 8);
  endtask

  task automatic test_clear;
    int np, nb;
    run_op(2, 77, 33, 5, 9, 0, 0, 0, 1'b0, np, nb);
    check_count("clear_plots", np, 19200);
    check_count("clear_busy", nb, 19200);
  endtask

  task automatic test_hold;
    int np, nb;
    run_op(0, 50, 60, 2, 2, 4, 1, 3, 1'b0, np, nb);
    check_count("hold_plots", np, 4);
    check_count("hold_busy", nb, 7);
  endtask

  task automatic test_zero_size;
    int np, nb;
    run_op(0, 5, 5, 0, 3, 1, 0, 0, 1'b0, np, nb);
    check_count("w0_busy", nb, 0);
    check_count("w0_plots", np, 0);
    run_op(1, 5, 5, 4, 0, 1, 0, 0, 1'b0, np, nb);
    check_count("h0_busy", nb, 0);
  endtask

  task automatic test_start_while_busy;
    int np, nb;
    run_op(0, 100, 100, 5, 3, 6, 2, 2, 1'b1, np, nb);
    check_count("noise_plots", np, 15);
    check_count("noise_busy", nb, 17);
  endtask

  task automatic test_reset_mid;
    int np, nb;
    Mode = 2'd0; X0 = 8'd30; Y0 = 7'd40; W = 8'd5; H = 7'd4; ColourIn = 3'd6;
    Start = 1'b1; Hold = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    @(negedge Clock);
    check_count("mid_busy_before_reset", int'(Busy), 1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check_all_zero("reset_mid_outputs");
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      checks++;
      if ({Plot, Busy, Done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_quiet k=%0d got pbd=%b exp=000", k, {Plot, Busy, Done});
      end
    end
    @(posedge Clock); #1;
    run_op(0, 1, 2, 3, 3, 2, 0, 0, 1'b0, np, nb);
    check_count("after_reset_plots", np, 9);
  endtask

  task automatic test_back_to_back;
    int np, nb;
    for (int n = 0; n < 24; n++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 127)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 8)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
             1'($urandom % 2), np, nb);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Hold = 1'b0; Mode = 2'd0;
    X0 = '0; Y0 = '0; W = '0; H = '0; ColourIn = '0;
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_hold();
    test_zero_size();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
